// File: rtl/jtag_tap_driver.sv
// Command-level JTAG initiator: runs TAP reset, IR scan and DR scan sequences on
// tck/tms/tdi and returns the captured tdo bits as one response per command.
module jtag_tap_driver #(
   parameter int TCK_DIV = 4,
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = 7
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic               cmd_reset_i,
   input  logic               cmd_ir_i,
   input  logic [LEN_W-1:0]   cmd_len_i,
   input  logic [MAX_LEN-1:0] cmd_data_i,
   output logic               rsp_valid_o,
   output logic [MAX_LEN-1:0] rsp_data_o,
   output logic               tck_pad_o,
   output logic               tms_pad_o,
   output logic               tdi_pad_o,
   input  logic               tdo_pad_i
);
   // state    | meaning
   // AUTO_RST | post-reset walk TMS=1,1,1,1,1,0 into Run-Test/Idle
   // READY    | parked in Run-Test/Idle, accepting commands
   // RST_SEQ  | commanded TAP reset, same walk as AUTO_RST
   // HEADER   | Idle to Shift-DR (1,0,0) or Shift-IR (1,1,0,0)
   // SHIFT    | len data bits, last one moves to Exit1
   // TRAILER  | Update then Idle (1,0)
   // DONE     | one-cycle response; also accepts the next command
   typedef enum logic [2:0] {
      AUTO_RST, READY, RST_SEQ, HEADER, SHIFT, TRAILER, DONE
   } state_t;

   localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [DIV_W-1:0] PH_LOAD = DIV_W'(TCK_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   state_t               state_q, state_d;
   logic                 tck_q, tck_d;
   logic                 tms_q, tms_d;
   logic                 tdi_q, tdi_d;
   logic [DIV_W-1:0]     ph_q, ph_d;
   logic [LEN_W-1:0]     bit_q, bit_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [MAX_LEN-1:0]   sr_q, sr_d;
   logic [MAX_LEN-1:0]   mask_q, mask_d;
   logic [MAX_LEN-1:0]   cap_q, cap_d;
   logic [MAX_LEN-1:0]   rsp_q, rsp_d;
   logic [LEN_W-1:0]     len_c;
   logic                 bit_start;

   // TMS for a TCK cycle is a function of the phase and the remaining-bit count
   function automatic logic tms_for(input state_t s, input logic [LEN_W-1:0] b);
      case (s)
         AUTO_RST, RST_SEQ, TRAILER: tms_for = (b != '0);
         HEADER:                     tms_for = (b >= LEN_W'(2));
         SHIFT:                      tms_for = (b == '0);
         default:                    tms_for = 1'b0;
      endcase
   endfunction

   assign len_c       = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
   assign cmd_ready_o = (state_q == READY) || (state_q == DONE);
   assign rsp_valid_o = (state_q == DONE);
   assign rsp_data_o  = rsp_q;
   assign tck_pad_o   = tck_q;
   assign tms_pad_o   = tms_q;
   assign tdi_pad_o   = tdi_q;

   always_comb begin
      state_d   = state_q;
      tck_d     = tck_q;
      tms_d     = tms_q;
      tdi_d     = tdi_q;
      ph_d      = ph_q;
      bit_d     = bit_q;
      len_d     = len_q;
      sr_d      = sr_q;
      mask_d    = mask_q;
      cap_d     = cap_q;
      rsp_d     = rsp_q;
      bit_start = 1'b0;
      case (state_q)
         READY, DONE: begin
            state_d = READY;
            if (cmd_valid_i && cmd_ready_o) begin
               ph_d      = PH_LOAD;
               tck_d     = 1'b0;
               bit_start = 1'b1;
               if (cmd_reset_i) begin
                  state_d = RST_SEQ;
                  bit_d   = LEN_W'(5);
               end else if (len_c == '0) begin
                  state_d = DONE;
                  rsp_d   = '0;
               end else begin
                  state_d = HEADER;
                  bit_d   = cmd_ir_i ? LEN_W'(3) : LEN_W'(2);
                  len_d   = len_c;
                  sr_d    = cmd_data_i;
                  mask_d  = {{(MAX_LEN-1){1'b0}}, 1'b1};
                  cap_d   = '0;
               end
            end
         end
         default: begin
            if (ph_q != '0) begin
               ph_d = ph_q - 1'b1;
            end else begin
               ph_d  = PH_LOAD;
               tck_d = ~tck_q;
               if (!tck_q) begin
                  if ((state_q == SHIFT) && tdo_pad_i) cap_d = cap_q | mask_q;
               end else begin
                  // high phase over: advance to the next TCK cycle
                  bit_start = 1'b1;
                  if (state_q == SHIFT) begin
                     sr_d   = sr_q >> 1;
                     mask_d = mask_q << 1;
                  end
                  if (bit_q != '0) begin
                     bit_d = bit_q - 1'b1;
                  end else begin
                     case (state_q)
                        AUTO_RST: state_d = READY;
                        RST_SEQ: begin
                           state_d = DONE;
                           rsp_d   = '0;
                        end
                        HEADER: begin
                           state_d = SHIFT;
                           bit_d   = len_q - 1'b1;
                        end
                        SHIFT: begin
                           state_d = TRAILER;
                           bit_d   = LEN_W'(1);
                        end
                        default: begin
                           state_d = DONE;
                           rsp_d   = cap_q;
                        end
                     endcase
                  end
               end
            end
         end
      endcase
      if (bit_start) begin
         tms_d = tms_for(state_d, bit_d);
         tdi_d = (state_d == SHIFT) ? sr_d[0] : 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= AUTO_RST;
         tck_q   <= 1'b0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         ph_q    <= PH_LOAD;
         bit_q   <= LEN_W'(5);
         len_q   <= '0;
         sr_q    <= '0;
         mask_q  <= '0;
         cap_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         tck_q   <= tck_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         len_q   <= len_d;
         sr_q    <= sr_d;
         mask_q  <= mask_d;
         cap_q   <= cap_d;
         rsp_q   <= rsp_d;
      end
   end
endmodule

// File: tb/tb_jtag_tap_driver.sv
// Self-checking bench for jtag_tap_driver: directed vector table, hand-written
// back-to-back and mid-scan reset sequences, and randomized commands vs. a model.
module tb_jtag_tap_driver;
   localparam int DIV = 4;
   localparam logic [63:0] IDCODE = 64'h14951185;
   localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                  PAUDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11,
                  EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_reset, cmd_ir;
   logic [6:0]  cmd_len;
   logic [63:0] cmd_data;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic        tck, tms, tdi, tdo;

   int          checks = 0;
   int          errors = 0;
   int          tdo_mode = 0;
   int          tck_cnt = 0;
   logic [127:0] tms_bits = '0;
   int          pulses = 0;
   int          tap = TLR;
   logic [63:0] dr_sr = '0;
   logic [3:0]  ir_sr = '0;
   logic [3:0]  ir_reg = '0;

   jtag_tap_driver #(.TCK_DIV(DIV), .MAX_LEN(64), .LEN_W(7)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_reset_i(cmd_reset),
      .cmd_ir_i   (cmd_ir),
      .cmd_len_i  (cmd_len),
      .cmd_data_i (cmd_data),
      .rsp_valid_o(rsp_valid),
      .rsp_data_o (rsp_data),
      .tck_pad_o  (tck),
      .tms_pad_o  (tms),
      .tdi_pad_o  (tdi),
      .tdo_pad_i  (tdo)
   );

   always #5 clk = ~clk;

   assign tdo = (tdo_mode == 1) ? dr_sr[0] : tdi;

   function automatic int tap_next(input int s, input logic m);
      case (s)
         TLR:     return m ? TLR   : RTI;
         RTI:     return m ? SELDR : RTI;
         SELDR:   return m ? SELIR : CAPDR;
         CAPDR:   return m ? EX1DR : SHDR;
         SHDR:    return m ? EX1DR : SHDR;
         EX1DR:   return m ? UPDR  : PAUDR;
         PAUDR:   return m ? EX2DR : PAUDR;
         EX2DR:   return m ? UPDR  : SHDR;
         UPDR:    return m ? SELDR : RTI;
         SELIR:   return m ? TLR   : CAPIR;
         CAPIR:   return m ? EX1IR : SHIR;
         SHIR:    return m ? EX1IR : SHIR;
         EX1IR:   return m ? UPIR  : PAUIR;
         PAUIR:   return m ? EX2IR : PAUIR;
         EX2IR:   return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   // Target-side TAP: records TMS per TCK rise and models IDCODE/IR registers
   always @(posedge tck) begin
      if (tck_cnt < 128) tms_bits[tck_cnt] = tms;
      tck_cnt++;
      case (tap)
         CAPDR:   dr_sr = IDCODE;
         SHDR:    dr_sr = dr_sr >> 1;
         SHIR:    ir_sr = {tdi, ir_sr[3:1]};
         UPIR:    ir_reg = ir_sr;
         default: ;
      endcase
      tap = tap_next(tap, tms);
   end

   always @(negedge clk) if (rsp_valid === 1'b1) pulses++;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] model_tms(input logic r, input logic ir, input int n);
      logic [127:0] v;
      int h;
      v = '0;
      if (r) begin
         for (int i = 0; i < 5; i++) v[i] = 1'b1;
      end else if (n > 0) begin
         h = ir ? 4 : 3;
         v[0] = 1'b1;
         if (ir) v[1] = 1'b1;
         v[h + n - 1] = 1'b1;
         v[h + n] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [63:0] model_rsp(input logic r, input int n, input logic [63:0] d);
      if (r || n == 0) return 64'd0;
      if (n >= 64) return d;
      return d & ((64'd1 << n) - 64'd1);
   endfunction

   function automatic int model_tck(input logic r, input logic ir, input int n);
      if (r) return 6;
      if (n == 0) return 0;
      return n + (ir ? 6 : 5);
   endfunction

   task automatic wait_ready(output int k);
      k = 0;
      while (k < 2000) begin
         @(negedge clk);
         k++;
         if (cmd_ready === 1'b1) break;
      end
   endtask

   task automatic do_cmd(input int id, input logic rc, input logic irc, input logic [6:0] lc,
                         input logic [63:0] dc, input logic [63:0] e_rsp, input int e_tck,
                         input logic [127:0] e_tms, input bit junk);
      int w, lat, p0;
      bit got;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      tck_cnt = 0;
      tms_bits = '0;
      p0 = pulses;
      cmd_valid = 1'b1; cmd_reset = rc; cmd_ir = irc; cmd_len = lc; cmd_data = dc;
      @(negedge clk);
      lat = 1;
      got = 1'b0;
      while (lat <= 3000) begin
         cmd_valid = junk && (lat < 5);
         cmd_reset = 1'(($urandom));
         cmd_ir    = 1'($urandom);
         cmd_len   = 7'($urandom);
         cmd_data  = {$urandom, $urandom};
         if (rsp_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      cmd_valid = 1'b0;
      chk($sformatf("cmd%0d rsp seen", id), got, 1);
      chk($sformatf("cmd%0d latency", id), lat, 2 * DIV * e_tck + 1);
      chk($sformatf("cmd%0d rsp_data", id), rsp_data, e_rsp);
      chk($sformatf("cmd%0d ready at pulse", id), cmd_ready, 1);
      chk($sformatf("cmd%0d tck count", id), tck_cnt, e_tck);
      chk($sformatf("cmd%0d tms seq", id), tms_bits, e_tms);
      chk($sformatf("cmd%0d tap idle", id), tap, RTI);
      @(negedge clk);
      chk($sformatf("cmd%0d pulse width", id), rsp_valid, 0);
      chk($sformatf("cmd%0d rsp held", id), rsp_data, e_rsp);
      chk($sformatf("cmd%0d pulse count", id), pulses - p0, 1);
   endtask

   typedef struct {
      logic         rst;
      logic         ir;
      logic [6:0]   len;
      logic [63:0]  data;
      int           mode;
      logic [63:0]  rsp;
      int           tck;
      logic [127:0] tms;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int k, p0, lat, n, et;
      bit got;
      logic r_r, ir_r;
      logic [6:0] len_r;
      logic [63:0] d_r;

      vecs[0] = '{1'b0, 1'b1, 7'd4,   64'h8,                 0, 64'h8,                 10, 128'h183};
      vecs[1] = '{1'b0, 1'b0, 7'd32,  64'h0,                 1, 64'h14951185,          37, 128'hC00000001};
      vecs[2] = '{1'b0, 1'b0, 7'd0,   64'hFFFF,              0, 64'h0,                 0,  128'h0};
      vecs[3] = '{1'b0, 1'b0, 7'd100, 64'h0123456789ABCDEF,  0, 64'h0123456789ABCDEF,  69, 128'hC0000000000000001};
      vecs[4] = '{1'b1, 1'b1, 7'd20,  64'hDEADBEEF,          0, 64'h0,                 6,  128'h1F};
      vecs[5] = '{1'b0, 1'b0, 7'd1,   64'h1,                 0, 64'h1,                 6,  128'h19};
      vecs[6] = '{1'b0, 1'b1, 7'd64,  64'hF00DCAFE12345678,  0, 64'hF00DCAFE12345678,  70, 128'h180000000000000003};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_reset = 1'b0; cmd_ir = 1'b0; cmd_len = '0; cmd_data = '0;
      repeat (3) @(negedge clk);
      chk("reset tck", tck, 0);
      chk("reset tms", tms, 1);
      chk("reset tdi", tdi, 0);
      chk("reset ready", cmd_ready, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_data", rsp_data, 0);

      tck_cnt = 0; tms_bits = '0; p0 = pulses;
      rst = 1'b0;
      wait_ready(k);
      chk("auto reset ready cycle", k, 2 * DIV * 6);
      chk("auto reset tck count", tck_cnt, 6);
      chk("auto reset tms seq", tms_bits, 128'h1F);
      chk("auto reset tap idle", tap, RTI);
      chk("auto reset no rsp", pulses - p0, 0);

      for (int i = 0; i < 7; i++) begin
         tdo_mode = vecs[i].mode;
         do_cmd(i, vecs[i].rst, vecs[i].ir, vecs[i].len, vecs[i].data,
                vecs[i].rsp, vecs[i].tck, vecs[i].tms, 1'b0);
         if (i == 0) chk("ir loaded", ir_reg, vecs[0].data[3:0]);
      end
      tdo_mode = 0;

      // back-to-back: cmd_valid held high across the first response
      p0 = pulses;
      cmd_valid = 1'b1; cmd_reset = 1'b0; cmd_ir = 1'b0; cmd_len = 7'd8; cmd_data = 64'hA5;
      @(negedge clk);
      cmd_data = 64'h3C;
      lat = 1; got = 1'b0;
      while (lat <= 2000) begin
         if (rsp_valid === 1'b1) begin got = 1'b1; break; end
         @(negedge clk); lat++;
      end
      chk("b2b first seen", got, 1);
      chk("b2b first latency", lat, 2 * DIV * 13 + 1);
      chk("b2b first data", rsp_data, 64'hA5);
      chk("b2b ready at pulse", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("b2b second accepted", cmd_ready, 0);
      chk("b2b pulse width", rsp_valid, 0);
      lat = 1; got = 1'b0;
      while (lat <= 2000) begin
         if (rsp_valid === 1'b1) begin got = 1'b1; break; end
         @(negedge clk); lat++;
      end
      chk("b2b second seen", got, 1);
      chk("b2b second latency", lat, 2 * DIV * 13 + 1);
      chk("b2b second data", rsp_data, 64'h3C);
      @(negedge clk);
      chk("b2b pulse count", pulses - p0, 2);

      // randomized commands against the model, with ignored junk while busy
      for (int i = 0; i < 24; i++) begin
         r_r   = ($urandom_range(0, 7) == 0);
         ir_r  = 1'($urandom);
         len_r = 7'($urandom_range(0, 70));
         d_r   = {$urandom, $urandom};
         n     = (int'(len_r) > 64) ? 64 : int'(len_r);
         et    = model_tck(r_r, ir_r, n);
         do_cmd(100 + i, r_r, ir_r, len_r, d_r, model_rsp(r_r, n, d_r), et,
                model_tms(r_r, ir_r, n), (et > 0) && ($urandom_range(0, 1) == 1));
      end

      // reset asserted mid-shift of a 16-bit DR scan
      p0 = pulses;
      cmd_valid = 1'b1; cmd_reset = 1'b0; cmd_ir = 1'b0; cmd_len = 7'd16; cmd_data = 64'hBEEF;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (29) @(negedge clk);
      chk("mid-scan tck high", tck, 1);
      rst = 1'b1;
      #1;
      chk("abort tck", tck, 0);
      chk("abort tms", tms, 1);
      chk("abort ready", cmd_ready, 0);
      chk("abort rsp_valid", rsp_valid, 0);
      tck_cnt = 0; tms_bits = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_ready(k);
      chk("re-reset ready cycle", k, 2 * DIV * 6);
      chk("re-reset tck count", tck_cnt, 6);
      chk("re-reset tms seq", tms_bits, 128'h1F);
      chk("re-reset tap idle", tap, RTI);
      chk("abort no rsp", pulses - p0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
